// File: rtl/ir_nec_transmitter_pkg.sv
// ir_pkg: shared state encoding and NEC unit-count constants for the IR transmitter
package ir_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEAD_MARK, ST_LEAD_SPACE, ST_BIT_MARK, ST_BIT_SPACE, ST_STOP_MARK, ST_GUARD
  } ir_tx_state_t;
  localparam int LEAD_MARK_U    = 16;
  localparam int LEAD_SPACE_U   = 8;
  localparam int REPEAT_SPACE_U = 4;
  localparam int ONE_SPACE_U    = 3;
  localparam int BIT_U          = 1;
  function automatic logic is_mark(ir_tx_state_t s);
    return s inside {ST_LEAD_MARK, ST_BIT_MARK, ST_STOP_MARK};
  endfunction
endpackage

// File: rtl/ir_nec_transmitter_if.sv
// ir_nec_transmitter_if: request/status bundle between a client and the NEC transmitter
interface ir_nec_transmitter_if;
  logic       start;
  logic       repeat_req;
  logic [7:0] address;
  logic [7:0] command;
  logic       ready;
  logic       busy;
  logic       done;
  logic       envelope;
  logic       ir_out;
  modport master (output start, repeat_req, address, command,
                  input ready, busy, done, envelope, ir_out);
  modport slave  (input start, repeat_req, address, command,
                  output ready, busy, done, envelope, ir_out);
endinterface

// File: rtl/ir_nec_transmitter_carrier.sv
// ir_carrier_gen: carrier phase counter; carrier_hi_o is the phase for the coming cycle
module ir_carrier_gen #(
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic carrier_hi_o
);
  localparam int CW = $clog2(CARRIER_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d = (restart_i || cnt_q == CW'(CARRIER_DIV - 1)) ? '0 : cnt_q + 1'b1;
  assign carrier_hi_o = cnt_d < CW'(CARRIER_HIGH);
  // free-running period counter, forced to phase 0 as a mark begins
  always_ff @(posedge clk)
    cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/ir_nec_transmitter.sv
// ir_nec_transmitter: NEC frame/repeat-code sequencer driving a 38 kHz modulated IR LED
module ir_nec_transmitter
  import ir_pkg::*;
#(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 439,
  parameter int GUARD_UNITS  = 72
) (
  input logic                 clk,
  input logic                 rst_n,
  ir_nec_transmitter_if.slave tx
);
  localparam int UW = $clog2((GUARD_UNITS > LEAD_MARK_U ? GUARD_UNITS : LEAD_MARK_U) + 1);
  localparam int CW = $clog2(UNIT_CYCLES + 1);
  ir_tx_state_t  state_q, state_d;
  logic [CW-1:0] cyc_q;
  logic [UW-1:0] unit_q, dur;
  logic [4:0]    bit_q;
  logic [31:0]   sh_q;
  logic          rpt_q, ready_q, done_q, env_q, ir_q;
  logic          accept, unit_end, st_end, mark_d, carrier_hi;
  assign accept   = ready_q & (tx.start | tx.repeat_req);
  assign unit_end = cyc_q == CW'(UNIT_CYCLES - 1);
  assign st_end   = unit_end && unit_q == dur - 1'b1;
  assign mark_d   = is_mark(state_d);
  // length of the current state in NEC units
  always_comb
    dur = state_q == ST_LEAD_MARK  ? UW'(LEAD_MARK_U) :
          state_q == ST_LEAD_SPACE ? (rpt_q ? UW'(REPEAT_SPACE_U) : UW'(LEAD_SPACE_U)) :
          state_q == ST_BIT_SPACE  ? (sh_q[0] ? UW'(ONE_SPACE_U) : UW'(BIT_U)) :
          state_q == ST_GUARD      ? UW'(GUARD_UNITS) : UW'(BIT_U);
  // next state: advance when the current state's unit budget is used up
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (accept) state_d = ST_LEAD_MARK;
      ST_LEAD_MARK:  if (st_end) state_d = ST_LEAD_SPACE;
      ST_LEAD_SPACE: if (st_end) state_d = rpt_q ? ST_STOP_MARK : ST_BIT_MARK;
      ST_BIT_MARK:   if (st_end) state_d = ST_BIT_SPACE;
      ST_BIT_SPACE:  if (st_end) state_d = &bit_q ? ST_STOP_MARK : ST_BIT_MARK;
      ST_STOP_MARK:  if (st_end) state_d = ST_GUARD;
      ST_GUARD:      if (st_end) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end
  // state, unit timer, payload shifter and registered outputs
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      rpt_q   <= 1'b0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      env_q   <= 1'b0;
      ir_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= (state_d != state_q || unit_end || state_q == ST_IDLE) ? '0 : cyc_q + 1'b1;
      unit_q  <= (state_d != state_q) ? '0 : unit_q + UW'(unit_end);
      if (accept) begin
        sh_q  <= {~tx.command, tx.command, ~tx.address, tx.address};
        rpt_q <= ~tx.start;
        bit_q <= '0;
      end else if (state_q == ST_BIT_SPACE && st_end) begin
        sh_q  <= sh_q >> 1;
        bit_q <= bit_q + 1'b1;
      end
      ready_q <= state_d == ST_IDLE;
      done_q  <= state_q == ST_STOP_MARK && st_end;
      env_q   <= mark_d;
      ir_q    <= mark_d & carrier_hi;
    end
  ir_carrier_gen #(
    .CARRIER_DIV (CARRIER_DIV),
    .CARRIER_HIGH(CARRIER_HIGH)
  ) u_carrier (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart_i   (mark_d & ~env_q),
    .carrier_hi_o(carrier_hi)
  );
  assign tx.ready    = ready_q;
  assign tx.busy     = ~ready_q;
  assign tx.done     = done_q;
  assign tx.envelope = env_q;
  assign tx.ir_out   = ir_q;
endmodule

// File: tb/tb_ir_nec_transmitter.sv
// tb_ir_nec_transmitter: segment-list model of NEC frames checked every cycle, plus literal timing checks
module tb_ir_nec_transmitter;
  localparam int UNIT  = 10;
  localparam int CDIV  = 4;
  localparam int CHIGH = 2;
  localparam int GUARD = 5;
  typedef struct packed {logic ready; logic done; logic env; logic ir;} exp_t;
  localparam exp_t IDLE_E = exp_t'(4'b1000);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  ir_nec_transmitter_if bus();
  ir_nec_transmitter #(
    .UNIT_CYCLES(UNIT), .CARRIER_DIV(CDIV), .CARRIER_HIGH(CHIGH), .GUARD_UNITS(GUARD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tx(bus)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc = 0;
  int idx0 = 0;
  bit started = 0;
  exp_t exp_q[$];
  exp_t cur = IDLE_E;
  bit prev_env = 0;
  int run_len = 0;
  int runs[$];
  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask
  function automatic void seg(input bit mark, input int units, input bit dn);
    exp_t e;
    for (int k = 0; k < units * UNIT; k++) begin
      e.ready = 1'b0;
      e.done  = dn && k == 0;
      e.env   = mark;
      e.ir    = mark && (k % CDIV) < CHIGH;
      exp_q.push_back(e);
    end
  endfunction
  function automatic void build(input bit rpt, input logic [7:0] a, input logic [7:0] c);
    logic [31:0] p;
    p = {~c, c, ~a, a};
    seg(1'b1, 16, 1'b0);
    seg(1'b0, rpt ? 4 : 8, 1'b0);
    if (!rpt)
      for (int i = 0; i < 32; i++) begin
        seg(1'b1, 1, 1'b0);
        seg(1'b0, p[i] ? 3 : 1, 1'b0);
      end
    seg(1'b1, 1, 1'b0);
    seg(1'b0, GUARD, 1'b1);
  endfunction
  function automatic int run_at(input int i);
    return i < runs.size() ? runs[i] : -1;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      cur = IDLE_E;
    end else begin
      if (cur.ready && (bus.start || bus.repeat_req))
        build(!bus.start, bus.address, bus.command);
      cur = exp_q.size() != 0 ? exp_q.pop_front() : IDLE_E;
    end
    started = 1;
  end
  always @(negedge clk)
    if (started)
      check("cycle {ready,busy,done,envelope,ir_out}",
            int'({bus.ready, bus.busy, bus.done, bus.envelope, bus.ir_out}),
            int'({cur.ready, ~cur.ready, cur.done, cur.env, cur.ir}));
  always @(negedge clk)
    if (bus.envelope !== prev_env) begin
      runs.push_back(run_len);
      run_len = 1;
      prev_env = bus.envelope;
    end else run_len++;
  task automatic req(input bit s, input bit r, input logic [7:0] a, input logic [7:0] c);
    @(negedge clk);
    bus.start = s;
    bus.repeat_req = r;
    bus.address = a;
    bus.command = c;
    idx0 = runs.size();
    @(posedge clk);
    #1;
    acc = cyc;
    bus.start = 1'b0;
    bus.repeat_req = 1'b0;
  endtask
  task automatic wait_done(output int n);
    int lim;
    lim = 0;
    do begin
      @(posedge clk);
      #1;
      lim++;
    end while (!bus.done && lim < 3000);
    n = cyc - acc;
  endtask
  task automatic wait_ready(output int m);
    int t0, lim;
    t0 = cyc;
    lim = 0;
    do begin
      @(posedge clk);
      #1;
      lim++;
    end while (!bus.ready && lim < 3000);
    m = cyc - t0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, m, hi;
    logic [3:0] pat;
    bus.start = 1'b0;
    bus.repeat_req = 1'b0;
    bus.address = 8'h00;
    bus.command = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", bus.ready, 1);
    check("reset busy", bus.busy, 0);
    check("reset envelope", bus.envelope, 0);
    check("reset ir_out", bus.ir_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    // 1: full frame addr 0x00 cmd 0x16
    req(1, 0, 8'h00, 8'h16);
    wait_done(n);
    check("t1 done latency", n, 1210);
    wait_ready(m);
    check("t1 ready after done", m, 50);
    check("t1 lead mark", run_at(idx0 + 1), 160);
    check("t1 lead space", run_at(idx0 + 2), 80);
    check("t1 addr bit0 space", run_at(idx0 + 4), 10);
    check("t1 ~addr bit0 space", run_at(idx0 + 20), 30);
    check("t1 cmd bit0 space", run_at(idx0 + 36), 10);
    check("t1 cmd bit1 space", run_at(idx0 + 38), 30);
    check("t1 ~cmd bit0 space", run_at(idx0 + 52), 30);
    check("t1 stop mark", run_at(idx0 + 67), 10);
    repeat (5) @(negedge clk);
    // 2/6: repeat code and carrier phase at mark start
    req(0, 1, 8'h12, 8'h34);
    pat[3] = bus.ir_out;
    for (int i = 2; i >= 0; i--) begin
      @(posedge clk);
      #1;
      pat[i] = bus.ir_out;
    end
    check("t2 ir_out first 4 mark cycles", pat, 4'b1100);
    wait_done(n);
    check("t2 done latency", n, 210);
    wait_ready(m);
    check("t2 ready after done", m, 50);
    check("t2 lead mark", run_at(idx0 + 1), 160);
    check("t2 repeat space", run_at(idx0 + 2), 40);
    check("t2 stop mark", run_at(idx0 + 3), 10);
    repeat (5) @(negedge clk);
    // 3: requests and input changes mid-frame are ignored
    req(1, 0, 8'hA5, 8'h3C);
    bus.address = 8'hFF;
    bus.command = 8'h00;
    repeat (300) @(negedge clk);
    bus.start = 1'b1;
    bus.repeat_req = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.repeat_req = 1'b0;
    wait_done(n);
    check("t3 done latency", n, 1210);
    check("t3 addr bit0 space", run_at(idx0 + 4), 30);
    wait_ready(m);
    check("t3 ready after done", m, 50);
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.envelope !== 1'b0 || bus.ready !== 1'b1) hi++;
    end
    check("t3 no queued frame", hi, 0);
    // 4: start wins over repeat_req
    req(1, 1, 8'h5A, 8'hC3);
    wait_done(n);
    check("t4 done latency", n, 1210);
    check("t4 lead space", run_at(idx0 + 2), 80);
    wait_ready(m);
    repeat (5) @(negedge clk);
    // 5: reset during lead space, then a clean frame
    req(1, 0, 8'h01, 8'h02);
    repeat (200) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t5 reset ir_out", bus.ir_out, 0);
    check("t5 reset envelope", bus.envelope, 0);
    check("t5 reset ready", bus.ready, 1);
    check("t5 reset done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    req(1, 0, 8'h01, 8'h02);
    wait_done(n);
    check("t5 done latency after reset", n, 1210);
    wait_ready(m);
    check("t5 ready after done", m, 50);
    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
